// File: rtl/ab_pkg.sv
// Shared types and constants for the 1A2B auto-solver and its judge.
// No logic; the candidate range below bounds the whole search.
// Candidates are 4-digit BCD codes with distinct digits.
package ab_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [15:0] FIRST_CAND = 16'h0123;
  localparam logic [15:0] LAST_CAND  = 16'h9876;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_WAIT_FB,
    S_STEP,
    S_CHECK,
    S_DONE,
    S_FAIL
  } state_e;

endpackage

// File: rtl/ab_auto_solver_if.sv
// Guess/score link between the solver (master) and the game judge (slave).
// A guess is held valid until the judge returns a one-cycle score pulse.
// There is no other flow control; the judge may answer at any time.
interface ab_auto_solver_if;

  logic [15:0] guess;
  logic        guess_valid;
  logic        fb_valid;
  logic [3:0]  fb_a;
  logic [3:0]  fb_b;

  modport master (
    output guess,
    output guess_valid,
    input  fb_valid,
    input  fb_a,
    input  fb_b
  );

  modport slave (
    input  guess,
    input  guess_valid,
    output fb_valid,
    output fb_a,
    output fb_b
  );

endinterface

// File: rtl/ab_score.sv
// Scores a candidate against a reference guess: A = same digit, same place,
// B = same digit, different place. Purely combinational, zero latency.
// No handshake; inputs are assumed to hold 4 distinct BCD digits each.
module ab_score
  import ab_pkg::*;
(
  input  logic [15:0] cand_i,
  input  logic [15:0] ref_i,
  output logic [2:0]  a_o,
  output logic [2:0]  b_o
);

  // Compare every reference digit against every candidate digit.
  always_comb begin
    a_o = '0;
    b_o = '0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (ref_i[j*DIGIT_W +: DIGIT_W] == cand_i[k*DIGIT_W +: DIGIT_W]) begin
          if (j == k) a_o = a_o + 3'd1;
          else        b_o = b_o + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ab_auto_solver.sv
// 1A2B player: guesses the smallest candidate consistent with all past scores.
// First guess two cycles after start; later guesses after a scan of STEP/CHECK cycles.
// Guess is held valid until the judge scores it; scores outside WAIT_FB are dropped.
module ab_auto_solver
  import ab_pkg::*;
#(
  parameter int MAX_TRY = 10
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  ab_auto_solver_if.master bus,
  output logic [3:0]       try_cnt,
  output logic             busy,
  output logic             solved,
  output logic             fail
);

  localparam logic [3:0] MAX_N = 4'(MAX_TRY);

  state_e      state_q, state_d;
  logic [15:0] cand_q, cand_d, cand_inc;
  logic [15:0] guess_q, guess_d;
  logic        guess_valid_q, guess_valid_d;
  logic [3:0]  try_q, try_d;
  logic [3:0]  n_q, n_d;
  logic [3:0]  idx_q, idx_d;
  logic        solved_q, solved_d;
  logic        fail_q, fail_d;
  logic        hist_we;

  // History is sized to the full 4-bit index range so any idx/n value is a
  // legal address; only the first MAX_TRY slots are ever written.
  logic [15:0] hist_g_q [16];
  logic [3:0]  hist_a_q [16];
  logic [3:0]  hist_b_q [16];

  logic [2:0]  sc_a, sc_b;
  logic        sc_match;

  function automatic logic distinct(input logic [15:0] c);
    return (c[15:12] != c[11:8]) && (c[15:12] != c[7:4]) && (c[15:12] != c[3:0]) &&
           (c[11:8]  != c[7:4])  && (c[11:8]  != c[3:0]) && (c[7:4]   != c[3:0]);
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] c);
    logic [15:0] r;
    logic        carry;
    r     = c;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  ab_score u_score (
    .cand_i (cand_q),
    .ref_i  (hist_g_q[idx_q]),
    .a_o    (sc_a),
    .b_o    (sc_b)
  );

  assign sc_match = ({1'b0, sc_a} == hist_a_q[idx_q]) && ({1'b0, sc_b} == hist_b_q[idx_q]);
  assign cand_inc = bcd_inc(cand_q);

  // Next-state and datapath updates for the game sequencer.
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    guess_d       = guess_q;
    guess_valid_d = guess_valid_q;
    try_d         = try_q;
    n_d           = n_q;
    idx_d         = idx_q;
    solved_d      = solved_q;
    fail_d        = fail_q;
    hist_we       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          cand_d   = FIRST_CAND;
          n_d      = 4'd0;
          try_d    = 4'd0;
          solved_d = 1'b0;
          fail_d   = 1'b0;
          state_d  = S_EMIT;
        end
      end
      S_EMIT: begin
        guess_d       = cand_q;
        guess_valid_d = 1'b1;
        try_d         = try_q + 4'd1;
        state_d       = S_WAIT_FB;
      end
      S_WAIT_FB: begin
        if (bus.fb_valid) begin
          hist_we       = 1'b1;
          n_d           = n_q + 4'd1;
          guess_valid_d = 1'b0;
          if (bus.fb_a == 4'd4) begin
            solved_d = 1'b1;
            state_d  = S_DONE;
          end else if (n_q + 4'd1 == MAX_N) begin
            fail_d  = 1'b1;
            state_d = S_FAIL;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        // The scan only moves upward: everything below was already rejected.
        if (cand_q == LAST_CAND) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          cand_d = cand_inc;
          if (distinct(cand_inc)) begin
            idx_d   = 4'd0;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (!sc_match)                state_d = S_STEP;
        else if (idx_q == n_q - 4'd1) state_d = S_EMIT;
        else                          idx_d   = idx_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath and score history registers.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      cand_q        <= 16'h0000;
      guess_q       <= 16'h0000;
      guess_valid_q <= 1'b0;
      try_q         <= 4'd0;
      n_q           <= 4'd0;
      idx_q         <= 4'd0;
      solved_q      <= 1'b0;
      fail_q        <= 1'b0;
      for (int e = 0; e < 16; e++) begin
        hist_g_q[e] <= 16'h0000;
        hist_a_q[e] <= 4'd0;
        hist_b_q[e] <= 4'd0;
      end
    end else begin
      cand_q        <= cand_d;
      guess_q       <= guess_d;
      guess_valid_q <= guess_valid_d;
      try_q         <= try_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      solved_q      <= solved_d;
      fail_q        <= fail_d;
      if (hist_we) begin
        hist_g_q[n_q] <= cand_q;
        hist_a_q[n_q] <= bus.fb_a;
        hist_b_q[n_q] <= bus.fb_b;
      end
    end
  end

  assign bus.guess       = guess_q;
  assign bus.guess_valid = guess_valid_q;
  assign try_cnt         = try_q;
  assign solved          = solved_q;
  assign fail            = fail_q;
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);

endmodule

// File: tb/tb_ab_auto_solver.sv
// Directed bench for ab_auto_solver: plays scripted judge scores against a
// MAX_TRY=10 instance and a MAX_TRY=1 instance, checking guesses and status.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ab_auto_solver;

  logic CLK = 1'b0;
  always #10 CLK = ~CLK;

  logic       rst;
  logic       start, start1;
  logic [3:0] try_cnt, try_cnt1;
  logic       busy, solved, fail;
  logic       busy1, solved1, fail1;

  ab_auto_solver_if bus ();
  ab_auto_solver_if bus1 ();

  ab_auto_solver #(.MAX_TRY(10)) dut (
    .CLK(CLK), .rst(rst), .start(start), .bus(bus),
    .try_cnt(try_cnt), .busy(busy), .solved(solved), .fail(fail)
  );

  ab_auto_solver #(.MAX_TRY(1)) dut1 (
    .CLK(CLK), .rst(rst), .start(start1), .bus(bus1),
    .try_cnt(try_cnt1), .busy(busy1), .solved(solved1), .fail(fail1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks are entered on a falling edge and return on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send_fb(input logic [3:0] a, input logic [3:0] b);
    bus.fb_valid = 1'b1;
    bus.fb_a     = a;
    bus.fb_b     = b;
    @(negedge CLK);
    bus.fb_valid = 1'b0;
  endtask

  task automatic expect_guess(input string tag, input int budget,
                              input logic [15:0] g, input logic [3:0] t);
    for (int c = 0; c < budget && !bus.guess_valid; c++) @(negedge CLK);
    chk({tag, "_vld"}, bus.guess_valid, 1);
    chk({tag, "_guess"}, bus.guess, g);
    chk({tag, "_try"}, try_cnt, t);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int c = 0; c < budget && busy; c++) @(negedge CLK);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    bus.fb_valid = 1'b0;  bus.fb_a = 4'd0;  bus.fb_b = 4'd0;
    bus1.fb_valid = 1'b0; bus1.fb_a = 4'd0; bus1.fb_b = 4'd0;
    repeat (3) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);

    // Reset state
    chk("rst_guess", bus.guess, 16'h0000);
    chk("rst_vld", bus.guess_valid, 0);
    chk("rst_try", try_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_solved", solved, 0);
    chk("rst_fail", fail, 0);

    // Secret 0123: first guess lands one cycle after EMIT
    pulse_start();
    chk("g1_busy_emit", busy, 1);
    chk("g1_vld_emit", bus.guess_valid, 0);
    @(negedge CLK);
    expect_guess("g1_first", 1, 16'h0123, 4'd1);
    send_fb(4'd4, 4'd0);
    chk("g1_solved", solved, 1);
    chk("g1_busy", busy, 0);
    chk("g1_try", try_cnt, 1);
    chk("g1_vld_drop", bus.guess_valid, 0);
    chk("g1_fail", fail, 0);

    // Secret 4567
    pulse_start();
    chk("g2_solved_clr", solved, 0);
    expect_guess("g2_first", 4, 16'h0123, 4'd1);
    send_fb(4'd0, 4'd0);
    chk("g2_step_vld", bus.guess_valid, 0);
    expect_guess("g2_second", 20000, 16'h4567, 4'd2);
    send_fb(4'd4, 4'd0);
    chk("g2_solved", solved, 1);
    chk("g2_try", try_cnt, 2);

    // Secret 1032: smallest derangement of 0123
    pulse_start();
    expect_guess("g3_first", 4, 16'h0123, 4'd1);
    send_fb(4'd0, 4'd4);
    expect_guess("g3_second", 20000, 16'h1032, 4'd2);
    send_fb(4'd4, 4'd0);
    chk("g3_solved", solved, 1);
    chk("g3_try", try_cnt, 2);

    // Inconsistent judge: scan runs off the end at 9876
    pulse_start();
    expect_guess("g4_first", 4, 16'h0123, 4'd1);
    send_fb(4'd0, 4'd0);
    expect_guess("g4_second", 20000, 16'h4567, 4'd2);
    send_fb(4'd0, 4'd0);
    wait_idle("g4", 20000);
    chk("g4_fail", fail, 1);
    chk("g4_solved", solved, 0);
    chk("g4_try", try_cnt, 2);
    chk("g4_guess_hold", bus.guess, 16'h4567);

    // MAX_TRY=1 instance: stray score in IDLE is ignored
    bus1.fb_valid = 1'b1; bus1.fb_a = 4'd4;
    @(negedge CLK);
    bus1.fb_valid = 1'b0;
    chk("m1_stray_solved", solved1, 0);
    chk("m1_stray_busy", busy1, 0);
    start1 = 1'b1;
    @(negedge CLK);
    start1 = 1'b1;  // second pulse lands in EMIT and must be ignored
    @(negedge CLK);
    start1 = 1'b0;
    chk("m1_vld", bus1.guess_valid, 1);
    chk("m1_guess", bus1.guess, 16'h0123);
    chk("m1_try", try_cnt1, 1);
    start1 = 1'b1;  // start while waiting for score
    @(negedge CLK);
    start1 = 1'b0;
    chk("m1_busy_start_try", try_cnt1, 1);
    chk("m1_busy_start_vld", bus1.guess_valid, 1);
    bus1.fb_valid = 1'b1; bus1.fb_a = 4'd1; bus1.fb_b = 4'd0;
    @(negedge CLK);
    bus1.fb_valid = 1'b0;
    chk("m1_fail", fail1, 1);
    chk("m1_busy", busy1, 0);
    chk("m1_try_end", try_cnt1, 1);
    bus1.fb_valid = 1'b1; bus1.fb_a = 4'd4;
    @(negedge CLK);
    bus1.fb_valid = 1'b0;
    chk("m1_stray_fail", fail1, 1);
    chk("m1_stray_solved2", solved1, 0);

    // Reset in the middle of a search
    pulse_start();
    expect_guess("r_first", 4, 16'h0123, 4'd1);
    send_fb(4'd0, 4'd0);
    repeat (40) @(negedge CLK);
    chk("r_busy_mid", busy, 1);
    rst = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    chk("r_vld", bus.guess_valid, 0);
    chk("r_try", try_cnt, 0);
    chk("r_busy", busy, 0);
    chk("r_guess", bus.guess, 16'h0000);
    chk("r_fail1", fail1, 0);
    pulse_start();
    chk("r_vld_emit", bus.guess_valid, 0);
    @(negedge CLK);
    expect_guess("r_restart", 1, 16'h0123, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ab_auto_solver.md
# ab_auto_solver

Automatic player for the 1A2B game: issues 4-digit BCD guesses with distinct digits to a game judge, consumes the returned A/B scores, and keeps guessing until the judge reports 4A or the game is lost. Each next guess is the smallest candidate consistent with every score received so far (consistent-guess strategy). Sits opposite the judge on the guess/score interface, on the 50 MHz domain, driving HEX/LED display logic through its status outputs.

## Interface

- MAX_TRY, 10 — history depth and guess limit (1..15)
- CLK  in  1  system clock, 50 MHz
- rst  in  1  reset; one clock, synchronous, active-low
- start  in  1  one-cycle pulse; begins a game; honoured only in IDLE, DONE, FAIL
- guess  out  16  current guess, BCD digits [15:12]..[3:0]; reset 16'h0000
- guess_valid  out  1  guess presented; held until feedback accepted; reset 0
- fb_valid  in  1  one-cycle pulse; judge score for the presented guess
- fb_a  in  4  exact-position matches (0..4)
- fb_b  in  4  wrong-position matches (0..4)
- try_cnt  out  4  guesses issued this game; reset 0
- busy  out  1  game in progress (not IDLE/DONE/FAIL); reset 0
- solved  out  1  last feedback was 4A; reset 0
- fail  out  1  no consistent candidate or MAX_TRY exhausted without 4A; reset 0

## Operation

- Candidate register cand: 4-digit BCD, scanned upward from 0123 to 9876; only candidates with 4 distinct digits are checked.
- History: MAX_TRY entries of {guess, a, b}; count n.
- Score of candidate c vs history guess g: A = positions with equal digits; B = digits of g present in c at a different position. Distinct digits guarantee A+B ≤ 4.
- States: IDLE, EMIT, WAIT_FB, STEP, CHECK, DONE, FAIL.
- IDLE/DONE/FAIL + start: cand=0123, n=0, try_cnt=0, solved=0, fail=0 → EMIT.
- EMIT: guess=cand, guess_valid=1, try_cnt+1 → WAIT_FB.
- WAIT_FB + fb_valid: store {cand, fb_a, fb_b} at history[n], n+1, guess_valid=0. If fb_a==4 → DONE, solved=1. Else if n+1==MAX_TRY → FAIL. Else → STEP.
- STEP: if cand==9876 → FAIL. Else cand=BCD increment (digit carry at 9). If new cand has repeated digits → stay in STEP. Else index i=0 → CHECK.
- CHECK: score cand vs history[i]; mismatch with stored a/b → STEP; match and i==n-1 → EMIT; else i+1.
- The scan never restarts: every candidate below the current guess was already rejected by a subset of the history.
- fb_valid outside WAIT_FB is ignored; start while busy is ignored; fb_a/fb_b are not range-checked (inconsistent scores simply lead to FAIL).
- rst low at any edge: every state, output, counter and history register returns to its reset value; state = IDLE.

## Timing

- start at edge k → state EMIT after k; guess=0123, guess_valid=1 after edge k+1.
- fb_valid at edge k (A≠4): STEP after k. Each STEP cycle advances cand by one code; each CHECK cycle tests one history entry.
- A candidate passing all n entries becomes guess_valid two edges after its last CHECK (last CHECK → EMIT, EMIT → WAIT_FB).
- solved/fail rise on the edge that accepts the terminal feedback, or on the STEP edge at cand==9876.
- solved/fail/guess/try_cnt hold until next start or rst.
- Worst-case search is ≈ 9876 STEP cycles plus 5040×MAX_TRY CHECK cycles (< 2 ms at 50 MHz).

## Structure

- Package ab_pkg: state enum; FIRST_CAND=16'h0123, LAST_CAND=16'h9876; BCD digit width 4.
- Sub-module ab_score: combinational scorer (two 16-bit BCD codes → 3-bit A, 3-bit B). Shared with the judge so both ends of the interface agree on scoring.
- Distinct-digit test and BCD increment are local functions.

## Test plan

- Judge secret 0123: start → guess 0123; fb 4A0B → solved=1, try_cnt=1, busy=0.
- Secret 4567: guess 0123, fb 0A0B → next guess 4567; fb 4A0B → solved, try_cnt=2.
- Secret 1032: guess 0123, fb 0A4B → next guess 1032 (smallest derangement); fb 4A → solved, try_cnt=2.
- Inconsistent judge: 0123→0A0B, 4567→0A0B → scan reaches 9876 → fail=1, try_cnt=2.
- MAX_TRY=1: guess 0123, fb 1A0B → fail=1 immediately, try_cnt=1; stray fb_valid and start-while-busy pulses ignored.
- rst low mid-CHECK during the 4567 game → guess_valid=0, try_cnt=0, busy=0, IDLE; a fresh start yields guess 0123 after one cycle.
